// File: rtl/rf_write_arbiter_if.sv
// Writeback requester handshakes and the register file write port of rf_write_arbiter.
interface rf_write_arbiter_if #(
    parameter int AdressWidth = 5,
    parameter int WIDTH       = 32
);
    logic                   HOLD;
    logic                   REQ0_VALID;
    logic [AdressWidth-1:0] REQ0_ADDR;
    logic [WIDTH-1:0]       REQ0_DATA;
    logic                   REQ0_READY;
    logic                   REQ1_VALID;
    logic [AdressWidth-1:0] REQ1_ADDR;
    logic [WIDTH-1:0]       REQ1_DATA;
    logic                   REQ1_READY;
    logic                   WE3;
    logic [AdressWidth-1:0] A3;
    logic [WIDTH-1:0]       WD3;
    logic                   LAST_GRANT;
    logic                   COLLIDE;

    // Drives requests, observes grants and the write port.
    modport master (
        output HOLD, REQ0_VALID, REQ0_ADDR, REQ0_DATA, REQ1_VALID, REQ1_ADDR, REQ1_DATA,
        input  REQ0_READY, REQ1_READY, WE3, A3, WD3, LAST_GRANT, COLLIDE
    );

    modport slave (
        input  HOLD, REQ0_VALID, REQ0_ADDR, REQ0_DATA, REQ1_VALID, REQ1_ADDR, REQ1_DATA,
        output REQ0_READY, REQ1_READY, WE3, A3, WD3, LAST_GRANT, COLLIDE
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between two writeback sources;
// the granted write is registered and presented one cycle after acceptance.
module rf_write_arbiter #(
    parameter int AdressWidth  = 5,
    parameter int WIDTH        = 32,
    parameter bit ZERO_DISCARD = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    rf_write_arbiter_if.slave bus
);
    typedef enum logic {
        GRANT0_LAST = 1'b0,
        GRANT1_LAST = 1'b1
    } grant_state_t;

    grant_state_t           state_reg, state_next;
    logic                   grant0, grant1;
    logic                   we_reg, we_next;
    logic [AdressWidth-1:0] a_reg, a_next;
    logic [WIDTH-1:0]       wd_reg, wd_next;
    logic                   collide_reg, collide_next;
    logic                   same_addr;

    assign same_addr = (bus.REQ0_ADDR == bus.REQ1_ADDR) && (bus.REQ0_ADDR != '0);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg   <= GRANT1_LAST;
            we_reg      <= 1'b0;
            a_reg       <= '0;
            wd_reg      <= '0;
            collide_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            we_reg      <= we_next;
            a_reg       <= a_next;
            wd_reg      <= wd_next;
            collide_reg <= collide_next;
        end
    end

    always_comb begin
        grant0       = 1'b0;
        grant1       = 1'b0;
        state_next   = state_reg;
        we_next      = 1'b0;
        a_next       = a_reg;
        wd_next      = wd_reg;
        collide_next = bus.REQ0_VALID && bus.REQ1_VALID && same_addr;

        // On a tie the requester that did not win last time goes first.
        if (RST && !bus.HOLD) begin
            if (bus.REQ0_VALID && bus.REQ1_VALID) begin
                if (state_reg == GRANT1_LAST) grant0 = 1'b1;
                else                          grant1 = 1'b1;
            end else if (bus.REQ0_VALID) begin
                grant0 = 1'b1;
            end else if (bus.REQ1_VALID) begin
                grant1 = 1'b1;
            end
        end

        if (grant0) begin
            state_next = GRANT0_LAST;
            a_next     = bus.REQ0_ADDR;
            wd_next    = bus.REQ0_DATA;
            we_next    = !(ZERO_DISCARD && (bus.REQ0_ADDR == '0));
        end else if (grant1) begin
            state_next = GRANT1_LAST;
            a_next     = bus.REQ1_ADDR;
            wd_next    = bus.REQ1_DATA;
            we_next    = !(ZERO_DISCARD && (bus.REQ1_ADDR == '0));
        end
    end

    assign bus.REQ0_READY = grant0;
    assign bus.REQ1_READY = grant1;
    assign bus.WE3        = we_reg;
    assign bus.A3         = a_reg;
    assign bus.WD3        = wd_reg;
    assign bus.LAST_GRANT = (state_reg == GRANT1_LAST);
    assign bus.COLLIDE    = collide_reg;
endmodule
